// File: rtl/seg7_decode_pkg.sv
// Shared definitions for the 7-segment receive path.
// Holds the blank pattern, the digit count, the FSM state type and the
// 16-entry glyph table (active-low {g,f,e,d,c,b,a}) that both the display
// driver and this decoder use, so the two sides always agree on glyphs.
package seg7_decode_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DIGITS    = 6;

    // Index n holds the active-low segment pattern of hex digit n.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic {
        ST_WAIT,
        ST_LOCKED
    } state_e;

    // Encoder helper for the transmit side.
    function automatic logic [6:0] glyph_enc(input logic [3:0] nib);
        return GLYPH_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_glyph_dec.sv
// Combinational glyph decoder: maps an active-low 7-segment pattern back to
// its hex nibble.
// Ports:
//   seg_i    [6:0] segment pattern {g,f,e,d,c,b,a}, active-low
//   legal_o        1 when seg_i matches one of the 16 hex glyphs
//   nibble_o [3:0] decoded value (0 when not legal)
module seg7_glyph_dec
    import seg7_decode_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        legal_o  = 1'b0;
        nibble_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == GLYPH_TABLE[i]) begin
                legal_o  = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_decode.sv
// Receive-side monitor for a multiplexed 6-digit 7-segment display bus.
// Samples {sel,seg}, accepts a digit once it has been stable long enough,
// decodes it and reassembles the 24-bit display word.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg   [7:0]  segment bus, active-low {dp,g,f,e,d,c,b,a}
//   sel   [2:0]  digit index 0..5, 6/7 = blank
//   data_out [23:0] last complete frame, digit k in [4k+3:4k]
//   data_valid   1-cycle pulse when data_out updates
//   pattern_err  1-cycle pulse on an accepted non-glyph pattern
//   sync_lost    1-cycle pulse when a partial frame times out
module seg7_decode
    import seg7_decode_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT       = 100000,
    parameter int IGNORE_DP     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg,
    input  logic [2:0]  sel,
    output logic [23:0] data_out,
    output logic        data_valid,
    output logic        pattern_err,
    output logic        sync_lost
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    logic [10:0]       pair_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    state_e            state_q, state_d;
    logic [DIGITS-1:0] seen_q, seen_d;
    logic [23:0]       shadow_q, shadow_d;
    logic [23:0]       data_q, data_d;
    logic              dv_q, dv_d;
    logic              pe_q, pe_d;
    logic              sl_q, sl_d;

    logic [2:0]        samp_sel;
    logic [7:0]        samp_seg;
    logic              pair_chg;
    logic              dec_legal;
    logic [3:0]        dec_nib;
    logic              glyph_ok;
    logic              accept;
    logic [DIGITS-1:0] seen_merge;

    assign samp_sel = pair_q[10:8];
    assign samp_seg = pair_q[7:0];
    assign pair_chg = ({sel, seg} != pair_q);

    seg7_glyph_dec u_dec (
        .seg_i    (samp_seg[6:0]),
        .legal_o  (dec_legal),
        .nibble_o (dec_nib)
    );

    // With dp checking enabled, a lit decimal point (seg[7]==0) poisons the glyph.
    assign glyph_ok = dec_legal && ((IGNORE_DP != 0) || samp_seg[7]);

    // Blank indices never accept, so they cannot refresh the timeout either.
    assign accept = (state_q == ST_WAIT) && (cnt_q == CNT_MAX) &&
                    (samp_sel <= 3'(DIGITS - 1));

    always_comb begin
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        state_d    = state_q;
        seen_d     = seen_q;
        shadow_d   = shadow_q;
        data_d     = data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        sl_d       = 1'b0;
        seen_merge = seen_q;

        // Stability counter saturates so a long dwell cannot wrap into a second acceptance.
        if (pair_chg) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (pair_chg) begin
            state_d = ST_WAIT;
        end else if (accept) begin
            state_d = ST_LOCKED;
        end

        if (accept) begin
            tmo_d = '0;
            if (glyph_ok) begin
                shadow_d[{samp_sel, 2'b00} +: 4] = dec_nib;
                seen_merge = seen_q | (DIGITS'(1) << samp_sel);
                if (seen_merge == {DIGITS{1'b1}}) begin
                    data_d = shadow_d;
                    dv_d   = 1'b1;
                    seen_d = '0;
                end else begin
                    seen_d = seen_merge;
                end
            end else begin
                pe_d             = 1'b1;
                seen_d[samp_sel] = 1'b0;
            end
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
            // Fires only on the step into saturation, hence once per silence.
            if ((tmo_q == TMO_MAX - 1'b1) && (seen_q != '0)) begin
                seen_d = '0;
                sl_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q   <= {3'b111, SEG_BLANK};
            cnt_q    <= '0;
            tmo_q    <= '0;
            state_q  <= ST_WAIT;
            seen_q   <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            sl_q     <= 1'b0;
        end else begin
            pair_q   <= {sel, seg};
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            state_q  <= state_d;
            seen_q   <= seen_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            pe_q     <= pe_d;
            sl_q     <= sl_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = dv_q;
    assign pattern_err = pe_q;
    assign sync_lost   = sl_q;

endmodule

// File: tb/tb_seg7_decode.sv
module tb_seg7_decode;

    localparam int SC   = 4;
    localparam int TO   = 200;
    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  seg = 8'hFF;
    logic [2:0]  sel = 3'd7;

    logic [23:0] data_out_a, data_out_b;
    logic        dv_a, pe_a, sl_a;
    logic        dv_b, pe_b, sl_b;

    // a: dp ignored, b: dp must be off
    seg7_decode #(.STABLE_CYCLES(SC), .TIMEOUT(TO), .IGNORE_DP(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .seg(seg), .sel(sel),
        .data_out(data_out_a), .data_valid(dv_a),
        .pattern_err(pe_a), .sync_lost(sl_a)
    );

    seg7_decode #(.STABLE_CYCLES(SC), .TIMEOUT(TO), .IGNORE_DP(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .seg(seg), .sel(sel),
        .data_out(data_out_b), .data_valid(dv_b),
        .pattern_err(pe_b), .sync_lost(sl_b)
    );

    always #5 clk = ~clk;

    // High-cycle counters sampled on the inactive edge.
    int dv_a_c = 0, pe_a_c = 0, sl_a_c = 0;
    int dv_b_c = 0, pe_b_c = 0;
    int both_c = 0;
    always @(negedge clk) begin
        if (dv_a) dv_a_c++;
        if (pe_a) pe_a_c++;
        if (sl_a) sl_a_c++;
        if (dv_b) dv_b_c++;
        if (pe_b) pe_b_c++;
        if (dv_a && sl_a) both_c++;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [2:0] s, input logic [7:0] g, input int n);
        @(negedge clk);
        sel = s;
        seg = g;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic blank(input int n);
        show(3'd7, 8'hFF, n);
    endtask

    // pats[8k+7:8k] is the pattern for digit k
    task automatic scan6(input logic [47:0] pats);
        for (int k = 0; k < 6; k++) show(3'(k), pats[8*k +: 8], HOLD);
        blank(6);
    endtask

    int dv0, pe0, sl0, dvb0, peb0;

    task automatic snap();
        dv0 = dv_a_c; pe0 = pe_a_c; sl0 = sl_a_c; dvb0 = dv_b_c; peb0 = pe_b_c;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset: asynchronous assertion checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data_out", 32'(data_out_a), 32'h0);
        chk("rst_data_valid", 32'(dv_a), 32'h0);
        chk("rst_pattern_err", 32'(pe_a), 32'h0);
        chk("rst_sync_lost", 32'(sl_a), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        blank(4);

        // full scan 1..6
        snap();
        scan6(48'h82_92_99_B0_A4_F9);
        chk("scan1_data", 32'(data_out_a), 32'h654321);
        chk("scan1_dv_cnt", 32'(dv_a_c - dv0), 32'd1);
        chk("scan1_pe_cnt", 32'(pe_a_c - pe0), 32'd0);

        // dwells one cycle short, separated by glitches
        snap();
        for (int k = 0; k < 6; k++) begin
            show(3'(k), 8'hC0, SC - 1);
            show(3'(k), 8'hFF, 1);
        end
        blank(6);
        chk("short_dv_cnt", 32'(dv_a_c - dv0), 32'd0);
        chk("short_pe_cnt", 32'(pe_a_c - pe0), 32'd0);
        chk("short_data", 32'(data_out_a), 32'h654321);

        // illegal glyph on digit 3
        snap();
        scan6(48'h92_99_7F_B0_A4_F9);
        chk("bad_pe_cnt", 32'(pe_a_c - pe0), 32'd1);
        chk("bad_dv_cnt", 32'(dv_a_c - dv0), 32'd0);
        blank(TO + 20);
        chk("bad_sl_cnt", 32'(sl_a_c - sl0), 32'd1);
        snap();
        scan6(48'hC6_83_88_90_80_F8);
        chk("clean_data", 32'(data_out_a), 32'hCBA987);
        chk("clean_dv_cnt", 32'(dv_a_c - dv0), 32'd1);

        // partial frame then silence
        snap();
        show(3'd0, 8'hF9, HOLD);
        show(3'd1, 8'hA4, HOLD);
        show(3'd2, 8'hB0, HOLD);
        blank(TO - 20);
        chk("tmo_early_sl", 32'(sl_a_c - sl0), 32'd0);
        blank(40);
        chk("tmo_sl_cnt", 32'(sl_a_c - sl0), 32'd1);
        chk("tmo_dv_cnt", 32'(dv_a_c - dv0), 32'd0);
        blank(TO + 20);
        chk("tmo_sl_once", 32'(sl_a_c - sl0), 32'd1);
        snap();
        scan6(48'h8E_86_A1_C6_83_88);
        chk("af_data", 32'(data_out_a), 32'hFEDCBA);
        chk("af_dv_cnt", 32'(dv_a_c - dv0), 32'd1);
        chk("af_sl_cnt", 32'(sl_a_c - sl0), 32'd0);

        // digit 0 with dp lit
        snap();
        scan6(48'h92_99_B0_A4_F9_40);
        chk("dp_ign_data", 32'(data_out_a), 32'h543210);
        chk("dp_ign_pe_cnt", 32'(pe_a_c - pe0), 32'd0);
        chk("dp_chk_pe_cnt", 32'(pe_b_c - peb0), 32'd1);
        chk("dp_chk_dv_cnt", 32'(dv_b_c - dvb0), 32'd0);
        chk("dp_chk_data", 32'(data_out_b), 32'hFEDCBA);

        // reset in the middle of a frame
        show(3'd0, 8'hF9, HOLD);
        show(3'd1, 8'hA4, HOLD);
        show(3'd2, 8'hB0, HOLD);
        show(3'd3, 8'h99, HOLD);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_data_a", 32'(data_out_a), 32'h0);
        chk("midrst_data_b", 32'(data_out_b), 32'h0);
        repeat (2) @(negedge clk);
        chk("midrst_pulses", {29'h0, dv_a, pe_a, sl_a}, 32'h0);
        rst_n = 1'b1;
        snap();
        scan6(48'h90_90_90_90_90_90);
        chk("nine_data_a", 32'(data_out_a), 32'h999999);
        chk("nine_dv_a", 32'(dv_a_c - dv0), 32'd1);
        chk("nine_data_b", 32'(data_out_b), 32'h999999);
        chk("nine_dv_b", 32'(dv_b_c - dvb0), 32'd1);

        chk("dv_sl_overlap", 32'(both_c), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
